// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared size/state encodings and request type for the data memory responder
package data_mem_responder_pkg;

  // req_size encodings
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // Responder FSM state encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  // Everything latched from the initiator at accept time
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        is_unsigned;
  } mem_req_t;

  // True when the size code is illegal or the byte lane is not naturally aligned for it
  function automatic logic bad_size_align(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lane[0];
      SIZE_WORD: bad = (lane != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_responder_load_store_align.sv
// rtl/data_mem_responder_load_store_align.sv - load lane select/extend and store lane merge
module load_store_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [3:0]  store_be,
  output logic [31:0] store_lanes
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte or half out of the stored word and extend it to 32 bits
  always_comb begin
    byte_sel = rword[7:0];
    case (lane)
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      2'd3:    byte_sel = rword[31:24];
      default: byte_sel = rword[7:0];
    endcase
    half_sel  = lane[1] ? rword[31:16] : rword[15:0];
    load_data = rword;
    case (size)
      SIZE_BYTE: load_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default:   load_data = rword;
    endcase
  end

  // Replicate right-aligned store data across the word and enable only the addressed lanes
  always_comb begin
    store_lanes = wdata;
    store_be    = 4'b0000;
    case (size)
      SIZE_BYTE: begin
        store_lanes = {4{wdata[7:0]}};
        store_be    = 4'b0001 << lane;
      end
      SIZE_HALF: begin
        store_lanes = {2{wdata[15:0]}};
        store_be    = lane[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_WORD: begin
        store_lanes = wdata;
        store_be    = 4'b1111;
      end
      default: begin
        store_lanes = wdata;
        store_be    = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding data memory with fixed response latency
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DATA_MEMORY_DEPTH = 128,
  parameter int          LATENCY           = 2,
  parameter logic [31:0] BASE_ADDR         = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int         IDX_W   = (DATA_MEMORY_DEPTH > 1) ? $clog2(DATA_MEMORY_DEPTH) : 1;
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  mem_req_t    req_q, req_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  logic [31:0] mem_q [DATA_MEMORY_DEPTH];

  mem_req_t    in_req;
  mem_req_t    cur_req;
  logic [31:0] offset;
  logic [29:0] word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic        cur_err;
  logic        enter_rsp;
  logic        mem_we;
  logic [31:0] load_data;
  logic [3:0]  store_be;
  logic [31:0] store_lanes;

  assign in_req = '{write:       req_write,
                    addr:        req_addr,
                    wdata:       req_wdata,
                    size:        req_size,
                    is_unsigned: req_unsigned};

  // With zero latency the commit happens on the accept edge, before req_q holds the request,
  // so the live inputs are used while in IDLE and the latched copy otherwise.
  assign cur_req  = (state_q == ST_IDLE) ? in_req : req_q;
  assign offset   = cur_req.addr - BASE_ADDR;
  assign word_idx = 30'(offset >> 2);
  assign mem_idx  = word_idx[IDX_W-1:0];

  // Range and alignment check for the request being committed
  always_comb begin
    cur_err = bad_size_align(cur_req.size, cur_req.addr[1:0]);
    if (cur_req.addr < BASE_ADDR) begin
      cur_err = 1'b1;
    end
    if ({2'b00, word_idx} >= 32'(DATA_MEMORY_DEPTH)) begin
      cur_err = 1'b1;
    end
  end

  load_store_align u_align (
    .size        (cur_req.size),
    .lane        (cur_req.addr[1:0]),
    .is_unsigned (cur_req.is_unsigned),
    .rword       (mem_q[mem_idx]),
    .wdata       (cur_req.wdata),
    .load_data   (load_data),
    .store_be    (store_be),
    .store_lanes (store_lanes)
  );

  // FSM next state, latency down-counter and request latch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d   = in_req;
          cnt_d   = LAT_CNT;
          state_d = (LATENCY == 0) ? ST_RESPOND : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_rsp = (state_q != ST_RESPOND) && (state_d == ST_RESPOND);
  assign mem_we    = enter_rsp && cur_req.write && !cur_err;

  // Response registers load on entry to RESPOND and clear once the response is taken
  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    if (enter_rsp) begin
      rsp_error_d = cur_err;
      rsp_rdata_d = (cur_err || cur_req.write) ? 32'h0 : load_data;
    end else if ((state_q == ST_RESPOND) && rsp_ready) begin
      rsp_error_d = 1'b0;
      rsp_rdata_d = 32'h0;
    end
  end

  // Control and response state, dropped immediately on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_q       <= '0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Array write port: byte-enabled store commit; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (store_be[i]) begin
          mem_q[mem_idx][8*i +: 8] <= store_lanes[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESPOND);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_a, req_valid_b;
  logic        rsp_ready_a, rsp_ready_b;
  logic        req_write;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        req_ready_a, req_ready_b;
  logic        rsp_valid_a, rsp_valid_b;
  logic        rsp_error_a, rsp_error_b;
  logic [31:0] rsp_rdata_a, rsp_rdata_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  data_mem_responder u_dut_a (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid_a),
    .req_ready    (req_ready_a),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid_a),
    .rsp_ready    (rsp_ready_a),
    .rsp_rdata    (rsp_rdata_a),
    .rsp_error    (rsp_error_a)
  );

  data_mem_responder #(.LATENCY(0)) u_dut_b (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid_b),
    .req_ready    (req_ready_b),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid_b),
    .rsp_ready    (rsp_ready_b),
    .rsp_rdata    (rsp_rdata_b),
    .rsp_error    (rsp_error_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One request/response on instance a (b=0) or b (b=1); hold = cycles of rsp_ready low
  task automatic run(input string tag, input bit b, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] sz, input bit uns, input int hold,
                     input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
    int n;
    int lat;
    logic [31:0] rd;
    logic er;
    req_write = wr; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = uns;
    if (b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    n = 0;
    while (!(b ? req_ready_b : req_ready_a) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready"}, 32'(b ? req_ready_b : req_ready_a), 32'd1);
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    lat = 1;
    while (!(b ? rsp_valid_b : rsp_valid_a) && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    rd = b ? rsp_rdata_b : rsp_rdata_a;
    er = b ? rsp_error_b : rsp_error_a;
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(er), 32'(exp_er));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(b ? rsp_valid_b : rsp_valid_a), 32'd1);
      check({tag, "_hold_rdata"}, b ? rsp_rdata_b : rsp_rdata_a, exp_rd);
      check({tag, "_hold_err"}, 32'(b ? rsp_error_b : rsp_error_a), 32'(exp_er));
      check({tag, "_hold_req_ready"}, 32'(b ? req_ready_b : req_ready_a), 32'd0);
    end
    if (b) rsp_ready_b = 1'b1; else rsp_ready_a = 1'b1;
    @(posedge clk); #1;
    rsp_ready_a = 1'b0; rsp_ready_b = 1'b0;
    check({tag, "_idle_ready"}, 32'(b ? req_ready_b : req_ready_a), 32'd1);
    check({tag, "_idle_valid"}, 32'(b ? rsp_valid_b : rsp_valid_a), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    rsp_ready_a = 1'b0; rsp_ready_b = 1'b0;
    req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_size = 2'b10; req_unsigned = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
    check("rst_rsp_rdata", rsp_rdata_a, 32'h0);
    check("rst_rsp_error", 32'(rsp_error_a), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_req_ready", 32'(req_ready_a), 32'd1);
    check("rst_req_ready_b", 32'(req_ready_b), 32'd1);

    // Word store and loads with lane select and extension
    run("st_w",   0, 1, 32'h1001_0004, 32'hDEAD_BEEF, 2'b10, 0, 0, 32'h0,         0, 3);
    run("ld_w",   0, 0, 32'h1001_0004, 32'h0,         2'b10, 0, 0, 32'hDEAD_BEEF, 0, 3);
    run("ld_bs",  0, 0, 32'h1001_0007, 32'h0,         2'b00, 0, 0, 32'hFFFF_FFDE, 0, 3);
    run("ld_bu",  0, 0, 32'h1001_0007, 32'h0,         2'b00, 1, 0, 32'h0000_00DE, 0, 3);
    run("ld_hs",  0, 0, 32'h1001_0004, 32'h0,         2'b01, 0, 0, 32'hFFFF_BEEF, 0, 3);
    run("ld_hu",  0, 0, 32'h1001_0006, 32'h0,         2'b01, 1, 0, 32'h0000_DEAD, 0, 3);
    run("ld_wu",  0, 0, 32'h1001_0004, 32'h0,         2'b10, 1, 0, 32'hDEAD_BEEF, 0, 3);

    // Errored requests leave the array untouched
    run("err_h",   0, 0, 32'h1001_0001, 32'h0,         2'b01, 0, 0, 32'h0, 1, 3);
    run("err_oor", 0, 0, 32'h1001_0200, 32'h0,         2'b10, 0, 0, 32'h0, 1, 3);
    run("err_blw", 0, 1, 32'h1000_FFFC, 32'h5555_5555, 2'b10, 0, 0, 32'h0, 1, 3);
    run("err_mis", 0, 1, 32'h1001_0006, 32'h0000_0000, 2'b10, 0, 0, 32'h0, 1, 3);
    run("err_sz",  0, 1, 32'h1001_0004, 32'h0000_0000, 2'b11, 0, 0, 32'h0, 1, 3);
    run("ld_keep", 0, 0, 32'h1001_0004, 32'h0,         2'b10, 0, 0, 32'hDEAD_BEEF, 0, 3);

    // Partial stores touch only their lanes
    run("st_b",   0, 1, 32'h1001_0005, 32'h0000_0011, 2'b00, 0, 0, 32'h0,         0, 3);
    run("ld_sb",  0, 0, 32'h1001_0004, 32'h0,         2'b10, 0, 0, 32'hDEAD_11EF, 0, 3);
    run("st_h",   0, 1, 32'h1001_0006, 32'h1234_7F00, 2'b01, 0, 0, 32'h0,         0, 3);
    run("ld_sh",  0, 0, 32'h1001_0004, 32'h0,         2'b10, 0, 0, 32'h7F00_11EF, 0, 3);

    // Last in-range word
    run("st_last", 0, 1, 32'h1001_01FC, 32'hCAFE_F00D, 2'b10, 0, 0, 32'h0,         0, 3);
    run("ld_last", 0, 0, 32'h1001_01FC, 32'h0,         2'b10, 0, 0, 32'hCAFE_F00D, 0, 3);

    // Backpressure: response held for 5 cycles
    run("bp", 0, 0, 32'h1001_0004, 32'h0, 2'b10, 0, 5, 32'h7F00_11EF, 0, 3);

    // Reset one cycle after accepting a store drops it
    run("st_old", 0, 1, 32'h1001_0008, 32'h1234_5678, 2'b10, 0, 0, 32'h0, 0, 3);
    req_write = 1'b1; req_addr = 32'h1001_0008; req_wdata = 32'hAAAA_5555;
    req_size = 2'b10; req_unsigned = 1'b0; req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    check("rw_in_wait", 32'(req_ready_a), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rw_rsp_valid", 32'(rsp_valid_a), 32'd0);
    check("rw_req_ready", 32'(req_ready_a), 32'd1);
    check("rw_rsp_rdata", rsp_rdata_a, 32'h0);
    #10;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rw_after_valid", 32'(rsp_valid_a), 32'd0);
    run("ld_old", 0, 0, 32'h1001_0008, 32'h0, 2'b10, 0, 0, 32'h1234_5678, 0, 3);

    // Zero-latency instance
    run("b_st", 1, 1, 32'h1001_0010, 32'h0BAD_F00D, 2'b10, 0, 0, 32'h0,         0, 1);
    run("b_ld", 1, 0, 32'h1001_0010, 32'h0,         2'b10, 0, 0, 32'h0BAD_F00D, 0, 1);
    run("b_hs", 1, 0, 32'h1001_0012, 32'h0,         2'b01, 0, 0, 32'h0000_0BAD, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
